// File: rtl/itch_framer.sv
// ITCH byte-stream framer: packs one message big-endian into seven registers.
// Optional FRAMER_STATS_EN adds saturating message and error counters.
module itch_framer #(
  parameter int REG_WIDTH  = 32,
  parameter int ADD_LEN    = 28,
  parameter int CANCEL_LEN = 12,
  parameter int EXEC_LEN   = 13
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic                 o_msg_valid,
  input  logic                 i_msg_ready,
`ifdef FRAMER_STATS_EN
  output logic [15:0]          o_msg_count,
  output logic [15:0]          o_err_count,
`endif
  output logic                 o_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD,
    DISCARD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [6:0][REG_WIDTH-1:0] regs;
  logic [4:0] count;
  logic [4:0] count_nx;
  logic [4:0] len;
  logic [4:0] type_len;
  logic       drain;
  logic       known;
  logic       xfer;
  logic       final_byte;
  logic       load;
  logic       store;
  logic       err_nx;
  logic       accept;

  assign o_ready     = (state != HOLD);
  assign o_msg_valid = (state == HOLD);
  assign xfer        = i_valid && o_ready;
  assign accept      = o_msg_valid && i_msg_ready;
  assign count_nx    = count + 5'd1;
  assign final_byte  = (count_nx == len);
  assign known       = (type_len != 5'd0);

  assign o_reg_1 = regs[0];
  assign o_reg_2 = regs[1];
  assign o_reg_3 = regs[2];
  assign o_reg_4 = regs[3];
  assign o_reg_5 = regs[4];
  assign o_reg_6 = regs[5];
  assign o_reg_7 = regs[6];

  // Map the type byte to its message length; zero marks an unknown type.
  always_comb begin
    type_len = 5'd0;
    case (i_data)
      8'h41:   type_len = ADD_LEN[4:0];
      8'h58:   type_len = CANCEL_LEN[4:0];
      8'h45:   type_len = EXEC_LEN[4:0];
      default: type_len = 5'd0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic plus datapath strobes and error request.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    store    = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (known) begin
            load     = 1'b1;
            state_nx = COLLECT;
          end else begin
            err_nx   = 1'b1;
            state_nx = i_last ? IDLE : DISCARD;
          end
        end
      end
      COLLECT: begin
        if (xfer) begin
          store = 1'b1;
          if (final_byte) begin
            state_nx = HOLD;
          end else if (i_last) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      HOLD: begin
        if (i_msg_ready) begin
          if (drain) begin
            err_nx   = 1'b1;
            state_nx = DISCARD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DISCARD: begin
        if (xfer && i_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Message registers, byte counter, latched length and drain flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs  <= '0;
      count <= 5'd0;
      len   <= 5'd0;
      drain <= 1'b0;
    end else if (load) begin
      regs            <= '0;
      regs[0][31:24]  <= i_data;
      len             <= type_len;
      count           <= 5'd1;
      drain           <= 1'b0;
    end else if (store) begin
      regs[count[4:2]][{~count[1:0], 3'b000} +: 8] <= i_data;
      count <= count_nx;
      if (final_byte) drain <= !i_last;
    end
  end

  // Registered single-cycle error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_err <= 1'b0;
    else       o_err <= err_nx;
  end

`ifdef FRAMER_STATS_EN
  // Saturating counters of accepted messages and error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_msg_count <= 16'd0;
      o_err_count <= 16'd0;
    end else begin
      if (accept && o_msg_count != 16'hFFFF)
        o_msg_count <= o_msg_count + 16'd1;
      if (o_err && o_err_count != 16'hFFFF)
        o_err_count <= o_err_count + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_itch_framer.sv
// Randomized bench for itch_framer against a frame-level reference model.
// Directed test-plan frames run first, then random frames.
module tb_itch_framer;

  typedef logic [6:0][31:0] msg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'd0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready;
  logic [31:0] r1, r2, r3, r4, r5, r6, r7;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic        err;
`ifdef FRAMER_STATS_EN
  logic [15:0] msg_count;
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  itch_framer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_valid     (valid),
    .i_last      (last),
    .o_ready     (ready),
    .o_reg_1     (r1),
    .o_reg_2     (r2),
    .o_reg_3     (r3),
    .o_reg_4     (r4),
    .o_reg_5     (r5),
    .o_reg_6     (r6),
    .o_reg_7     (r7),
    .o_msg_valid (msg_valid),
    .i_msg_ready (msg_ready),
`ifdef FRAMER_STATS_EN
    .o_msg_count (msg_count),
    .o_err_count (err_count),
`endif
    .o_err       (err)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] byte_q[$];
  bit         last_q[$];
  bit         done_q[$];
  msg_t       exp_q[$];
  logic [7:0] fr[$];
  int         exp_err = 0;
  int         seen_err = 0;
  int         got_msgs = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int len_of(input logic [7:0] t);
    case (t)
      8'h41:   return 28;
      8'h58:   return 12;
      8'h45:   return 13;
      default: return 0;
    endcase
  endfunction

  task automatic build(input logic [7:0] t, input int n);
    fr.delete();
    fr.push_back(t);
    for (int i = 1; i < n; i++) fr.push_back(8'($urandom));
  endtask

  // Reference model: derive expected messages and errors per frame.
  task automatic push_frame();
    int   n;
    int   l;
    msg_t m;
    n = fr.size();
    l = len_of(fr[0]);
    m = '0;
    for (int i = 0; i < n; i++) begin
      byte_q.push_back(fr[i]);
      last_q.push_back(i == n - 1);
      done_q.push_back(l != 0 && n >= l && i == l - 1);
    end
    if (l == 0 || n < l) begin
      exp_err++;
    end else begin
      for (int k = 0; k < l; k++)
        m[k / 4][8 * (3 - k % 4) +: 8] = fr[k];
      exp_q.push_back(m);
      if (n > l) exp_err++;
    end
  endtask

  task automatic run();
    int   cyc;
    int   idle;
    bit   pend;
    bit   prev_hold;
    msg_t prev;
    msg_t cur;
    msg_t m;
    cyc = 0;
    idle = 0;
    pend = 0;
    prev_hold = 0;
    prev = '0;
    while (idle < 4 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      cur = {r7, r6, r5, r4, r3, r2, r1};
      if (err) seen_err++;
      if (pend) check("latency", 32'(msg_valid), 32'd1);
      pend = 0;
      if (msg_valid) check("ready_hold", 32'(ready), 32'd0);
      if (prev_hold && msg_valid)
        check("hold_stable", 32'(cur == prev), 32'd1);
      msg_ready = ($urandom % 3) != 0;
      if (msg_valid && msg_ready) begin
        got_msgs++;
        if (exp_q.size() == 0) begin
          check("extra_msg", 32'd1, 32'd0);
        end else begin
          m = exp_q.pop_front();
          for (int j = 0; j < 7; j++)
            check($sformatf("reg%0d", j + 1), cur[j], m[j]);
        end
      end
      prev_hold = msg_valid && !msg_ready;
      prev = cur;
      if (byte_q.size() > 0 && ($urandom % 4) != 0) begin
        valid = 1'b1;
        data  = byte_q[0];
        last  = last_q[0];
      end else begin
        valid = 1'b0;
        data  = 8'($urandom);
        last  = 1'($urandom);
      end
      if (valid && ready) begin
        void'(byte_q.pop_front());
        void'(last_q.pop_front());
        pend = done_q.pop_front();
      end
      if (byte_q.size() == 0 && !msg_valid && !valid && !pend) idle++;
      else idle = 0;
    end
    if (cyc >= 40000) check("timeout", 32'd0, 32'd1);
    valid = 1'b0;
  endtask

  initial begin
    logic [7:0] t;
    int         sel;
    int         n;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(msg_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_reg1", r1, 32'd0);
    check("rst_reg7", r7, 32'd0);
    rst = 1'b0;

    build(8'h41, 28); push_frame();
    build(8'h58, 12); push_frame();
    build(8'h45, 13); fr[11] = 8'hAB; fr[12] = 8'hCD; push_frame();
    build(8'h41, 10); push_frame();
    build(8'h58, 12); push_frame();
    build(8'h7A, 5);  push_frame();
    build(8'h41, 28); push_frame();
    build(8'h58, 16); push_frame();
    build(8'h45, 13); fr[11] = 8'hAB; fr[12] = 8'hCD; push_frame();

    for (int f = 0; f < 50; f++) begin
      sel = $urandom % 4;
      if (sel == 0) t = 8'h41;
      else if (sel == 1) t = 8'h58;
      else if (sel == 2) t = 8'h45;
      else begin
        t = 8'($urandom);
        while (len_of(t) != 0) t = 8'($urandom);
      end
      if (sel < 3) begin
        n = len_of(t) + $urandom_range(0, 6) - 3;
        if (n < 2) n = 2;
      end else begin
        n = $urandom_range(1, 6);
      end
      build(t, n);
      push_frame();
    end

    run();
    check("err_total", 32'(seen_err), 32'(exp_err));
    check("msgs_left", 32'(exp_q.size()), 32'd0);
`ifdef FRAMER_STATS_EN
    check("msg_count", 32'(msg_count), 32'(got_msgs));
    check("err_count", 32'(err_count), 32'(exp_err));
`endif

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = (i == 0) ? 8'h41 : 8'($urandom);
      last  = 1'b0;
    end
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_reg1", r1, 32'd0);
    check("mid_rst_reg2", r2, 32'd0);
    check("mid_rst_valid", 32'(msg_valid), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    exp_err = 0;
    seen_err = 0;
    build(8'h58, 12);
    push_frame();
    run();
    check("post_rst_err", 32'(seen_err), 32'(exp_err));
    check("post_rst_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
